// File: rtl/osc_pkg.sv
// Shared encodings for the oscilloscope acquisition controller.
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } osc_state_t;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/osc_trig_detect.sv
// Edge trigger and auto-timeout detector; o_trig is combinational and aligned with i_strobe.
module osc_trig_detect
  import osc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_strobe,
  input  logic              i_track,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_slope,
  input  logic              i_auto,
  input  logic [TMO_W-1:0]  i_auto_tmo,
  output logic              o_trig
);

  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              w_edge;
  logic              w_auto_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      if (i_clr) begin
        r_prev_valid <= 1'b0;
      end else if (i_strobe && i_track) begin
        r_prev       <= i_data;
        r_prev_valid <= 1'b1;
      end
      // Timeout only runs while armed, so it restarts at zero on every ARMED entry.
      if (!i_enable) begin
        r_tmo_cnt <= '0;
      end else if (i_strobe) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign w_edge = (i_slope == SLOPE_FALL) ? ((r_prev > i_level) && (i_data <= i_level))
                                          : ((r_prev < i_level) && (i_data >= i_level));
  assign w_auto_hit = i_auto && (r_tmo_cnt == i_auto_tmo);
  assign o_trig = i_strobe && i_enable && ((r_prev_valid && w_edge) || w_auto_hit);

endmodule

// File: rtl/osc_acq_ctrl.sv
// Acquisition controller: decimates ADC samples, writes them circularly into the capture RAM,
// and stops a programmed number of samples after an edge or auto trigger.
module osc_acq_ctrl
  import osc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [7:0]        decim,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              trig_auto,
  input  logic [TMO_W-1:0]  auto_tmo,
  input  logic [ADDR_W-1:0] pre_len,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              triggered,
  output logic              cap_done,
  output logic [2:0]        o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  osc_state_t        r_state;
  logic [7:0]        r_decim;
  logic [7:0]        r_dcnt;
  logic [ADDR_W-1:0] r_pre_l;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_level;
  logic              r_slope;
  logic              r_we;
  logic [ADDR_W-1:0] r_buf_waddr;
  logic [DATA_W-1:0] r_buf_wdata;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_start_addr;
  logic              r_triggered;

  logic w_strobe;
  logic w_arm_ok;
  logic w_capture;
  logic w_track;
  logic w_armed;
  logic w_trig;

  assign w_strobe  = adc_valid && (r_dcnt == r_decim);
  assign w_arm_ok  = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_track   = (r_state == ST_FILL) || (r_state == ST_ARMED);
  assign w_armed   = (r_state == ST_ARMED);
  assign w_capture = w_track || (r_state == ST_POST);

  osc_trig_detect #(
    .DATA_W(DATA_W),
    .TMO_W (TMO_W)
  ) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_arm_ok),
    .i_strobe  (w_strobe),
    .i_track   (w_track),
    .i_enable  (w_armed),
    .i_data    (adc_data),
    .i_level   (r_level),
    .i_slope   (r_slope),
    .i_auto    (trig_auto),
    .i_auto_tmo(auto_tmo),
    .o_trig    (w_trig)
  );

  // r_cnt counts fill writes in FILL and remaining post-trigger writes in POST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_decim      <= '0;
      r_dcnt       <= '0;
      r_pre_l      <= '0;
      r_waddr      <= '0;
      r_cnt        <= '0;
      r_level      <= '0;
      r_slope      <= SLOPE_RISE;
      r_we         <= 1'b0;
      r_buf_waddr  <= '0;
      r_buf_wdata  <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_triggered  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (adc_valid) begin
        r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
      end
      if (abort) begin
        r_state <= ST_IDLE;
      end else if (w_arm_ok) begin
        // pre_len is ADDR_W wide, so it can never exceed DEPTH-1.
        r_pre_l     <= pre_len;
        r_decim     <= decim;
        r_slope     <= trig_slope;
        r_level     <= trig_level;
        r_triggered <= 1'b0;
        r_dcnt      <= '0;
        r_waddr     <= '0;
        r_cnt       <= '0;
        r_state     <= (pre_len == '0) ? ST_ARMED : ST_FILL;
      end else if (w_strobe && w_capture) begin
        r_we        <= 1'b1;
        r_buf_waddr <= r_waddr;
        r_buf_wdata <= adc_data;
        r_waddr     <= r_waddr + 1'b1;
        case (r_state)
          ST_FILL: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_pre_l - 1'b1) begin
              r_state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (w_trig) begin
              r_trig_addr  <= r_waddr;
              r_start_addr <= r_waddr - r_pre_l;
              r_triggered  <= 1'b1;
              r_cnt        <= LAST_ADDR - r_pre_l;
              r_state      <= (r_pre_l == LAST_ADDR) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == 1) begin
              r_state <= ST_DONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign buf_we      = r_we;
  assign buf_waddr   = r_buf_waddr;
  assign buf_wdata   = r_buf_wdata;
  assign trig_addr   = r_trig_addr;
  assign start_addr  = r_start_addr;
  assign triggered   = r_triggered;
  assign busy        = w_capture;
  assign cap_done    = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_osc_acq_ctrl.sv
// Scoreboard bench for osc_acq_ctrl with a 16-entry capture buffer.
module tb_osc_acq_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int TMO_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [7:0]        decim = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_slope = 1'b0;
  logic              trig_auto = 1'b0;
  logic [TMO_W-1:0]  auto_tmo = '0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              triggered;
  logic              cap_done;
  logic [2:0]        o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_w;

  osc_acq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .trig_auto  (trig_auto),
    .auto_tmo   (auto_tmo),
    .pre_len    (pre_len),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .trig_addr  (trig_addr),
    .start_addr (start_addr),
    .busy       (busy),
    .triggered  (triggered),
    .cap_done   (cap_done),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected write addr=%0d data=%0d", buf_waddr, buf_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({buf_waddr, buf_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   buf_waddr, buf_wdata, exp_w[DATA_W +: ADDR_W], exp_w[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [ADDR_W-1:0] pre, input logic [DATA_W-1:0] lvl,
                        input logic slope, input logic [7:0] dec);
    pre_len    = pre;
    trig_level = lvl;
    trig_slope = slope;
    decim      = dec;
    adc_valid  = 1'b0;
    arm        = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic push(input int a, input int d);
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    pa = ADDR_W'(a % 16);
    pd = DATA_W'(d);
    exp_q.push_back({pa, pd});
  endtask

  task automatic drain_check(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  logic [DATA_W-1:0] sine_v[7];

  initial begin
    sine_v = '{8'd200, 8'd100, 8'd140, 8'd200, 8'd150, 8'd129, 8'd128};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we", buf_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", cap_done, 0);
    chk("reset_trig", triggered, 0);
    chk("reset_state", o_dbg_state, 0);
    rst_n = 1'b1;
    cyc(0, 0);

    // Rising ramp, level 100, 4 pre-trigger samples
    do_arm(4, 100, 0, 0);
    chk("t1_busy", busy, 1);
    chk("t1_state_fill", o_dbg_state, 1);
    for (int s = 0; s <= 111; s++) push(s, s);
    for (int s = 0; s <= 130; s++) cyc(1, DATA_W'(s));
    cyc(0, 0);
    chk("t1_trig_addr", trig_addr, 4);
    chk("t1_start_addr", start_addr, 0);
    chk("t1_cap_done", cap_done, 1);
    chk("t1_triggered", triggered, 1);
    chk("t1_busy_end", busy, 0);
    drain_check("t1_queue");

    // Falling slope through 128; earlier crossings in FILL and rising ones are ignored
    do_arm(2, 128, 1, 0);
    for (int i = 0; i < 7; i++) push(i, sine_v[i]);
    for (int i = 0; i < 13; i++) push(7 + i, 60 + i);
    for (int i = 0; i < 7; i++) cyc(1, sine_v[i]);
    for (int i = 0; i < 20; i++) cyc(1, DATA_W'(60 + i));
    cyc(0, 0);
    chk("t2_trig_addr", trig_addr, 6);
    chk("t2_start_addr", start_addr, 4);
    chk("t2_cap_done", cap_done, 1);
    drain_check("t2_queue");

    // Auto trigger on constant input after 20 armed strobes
    trig_auto = 1'b1;
    auto_tmo  = 16'd20;
    do_arm(3, 100, 0, 0);
    for (int i = 0; i <= 35; i++) push(i, 50);
    for (int i = 0; i < 45; i++) cyc(1, 8'd50);
    cyc(0, 0);
    chk("t3_trig_addr", trig_addr, 7);
    chk("t3_start_addr", start_addr, 4);
    chk("t3_triggered", triggered, 1);
    chk("t3_cap_done", cap_done, 1);
    drain_check("t3_queue");
    trig_auto = 1'b0;

    // decim=3 with gaps between valid samples; pre_len=15 finishes on the trigger write
    do_arm(15, 100, 0, 3);
    for (int m = 0; m <= 25; m++) push(m, 4 * m + 3);
    for (int j = 0; j < 120; j++) begin
      cyc(1, DATA_W'(j));
      cyc(0, 0);
    end
    chk("t4_trig_addr", trig_addr, 9);
    chk("t4_start_addr", start_addr, 10);
    chk("t4_cap_done", cap_done, 1);
    drain_check("t4_queue");

    // Abort in POST
    do_arm(4, 10, 0, 0);
    for (int s = 0; s <= 13; s++) push(s, s);
    for (int s = 0; s <= 13; s++) cyc(1, DATA_W'(s));
    abort = 1'b1;
    cyc(1, 8'd14);
    abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", cap_done, 0);
    chk("t5_abort_trig_kept", triggered, 1);
    chk("t5_abort_state", o_dbg_state, 0);
    for (int s = 20; s < 26; s++) cyc(1, DATA_W'(s));
    cyc(0, 0);
    drain_check("t5_queue");

    // Re-arm with no pre-trigger samples
    do_arm(0, 100, 0, 0);
    chk("t5_rearm_state", o_dbg_state, 2);
    for (int s = 95; s <= 115; s++) push(s - 95, s);
    for (int s = 95; s <= 120; s++) cyc(1, DATA_W'(s));
    cyc(0, 0);
    chk("t5_rearm_trig_addr", trig_addr, 5);
    chk("t5_rearm_start_addr", start_addr, 5);
    chk("t5_rearm_done", cap_done, 1);
    drain_check("t5_rearm_queue");

    // arm and abort together: abort wins
    arm   = 1'b1;
    abort = 1'b1;
    cyc(0, 0);
    arm   = 1'b0;
    abort = 1'b0;
    chk("t5_armabort_state", o_dbg_state, 0);
    chk("t5_armabort_done", cap_done, 0);
    chk("t5_armabort_busy", busy, 0);
    for (int s = 0; s < 5; s++) cyc(1, DATA_W'(s));
    cyc(0, 0);
    drain_check("t5_armabort_queue");

    // Arm while busy is ignored, then asynchronous reset mid-ARMED
    do_arm(2, 200, 0, 0);
    for (int s = 0; s <= 12; s++) push(s, s);
    for (int s = 0; s <= 9; s++) cyc(1, DATA_W'(s));
    do_arm(5, 20, 1, 0);
    for (int s = 10; s <= 12; s++) cyc(1, DATA_W'(s));
    cyc(0, 0);
    chk("t6_state_armed", o_dbg_state, 2);
    chk("t6_busy", busy, 1);
    drain_check("t6_queue");
    cyc(1, 8'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", buf_we, 0);
    chk("t6_rst_waddr", buf_waddr, 0);
    chk("t6_rst_wdata", buf_wdata, 0);
    chk("t6_rst_trig_addr", trig_addr, 0);
    chk("t6_rst_start_addr", start_addr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_triggered", triggered, 0);
    chk("t6_rst_done", cap_done, 0);
    chk("t6_rst_state", o_dbg_state, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
